pe_acc_sched: RTL and testbench

//  Accumulation scheduler for one PE and its 32-entry local cache. Sequences a layer as
//  K input chunks x S output slots (chunk-major, slot-minor) and drives cache rd/wr addresses,

---
 rtl/drl_pkg.sv | 16 +
 rtl/pe_acc_wb_pipe.sv | 43 ++++
 rtl/pe_acc_sched.sv | 141 ++++++++++++++
 tb/tb_pe_acc_sched.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/drl_pkg.sv
// Shared types and cache geometry for the PE accumulation scheduler.
// Cache entries at CACHE_RSVD_BASE and above are reserved and never addressed.
package drl_pkg;

    localparam int CACHE_ADDR_W    = 5;
    localparam int CACHE_RSVD_BASE = 29;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/pe_acc_wb_pipe.sv
// Writeback stage: delays an issue by one cycle to line up with the PE's registered sum.
// Latency 1 cycle; no backpressure, a dropped issue simply yields no writeback.
// Backpressure: none; the upstream stalls by not issuing.
module pe_acc_wb_pipe #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_slot,
    input  logic              issue_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              pe_done,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_slot
);

    logic              vld_q;
    logic              last_q;
    logic [ADDR_W-1:0] slot_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            slot_q <= '0;
        end else begin
            vld_q <= issue;
            if (issue) begin
                last_q <= issue_last;
                slot_q <= issue_slot;
            end
        end
    end

    assign wr_en     = vld_q;
    assign wr_addr   = slot_q;
    assign pe_done   = vld_q & last_q;
    assign out_valid = vld_q & last_q;
    assign out_slot  = slot_q;

endmodule

// File: rtl/pe_acc_sched.sv
// Sequences K chunks x S slots into one PE and its local cache; PE_ACC_SCHED_PERF_EN adds perf counters.
// Latency: clear 1 cycle after start, writeback/final-sum flag 1 cycle after each issue, done 2 after last.
// Backpressure: in_valid low in RUN stalls the sequence; cfg_start is ignored while busy.
module pe_acc_sched
    import drl_pkg::*;
#(
    parameter int NUM_SLOTS = CACHE_RSVD_BASE,
    parameter int ADDR_W    = CACHE_ADDR_W,
    parameter int CNT_W     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_num_slots,
    input  logic [CNT_W-1:0]  cfg_num_chunks,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              pe_cache_clear,
    output logic [ADDR_W-1:0] pe_cache_rd_addr,
    output logic [ADDR_W-1:0] pe_cache_wr_addr,
    output logic              pe_cache_wr_en,
    output logic              pe_bias_en,
    output logic              pe_done,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_slot
`ifdef PE_ACC_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_issue_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] num_slots_q, s_cnt, last_rd_q;
    logic [CNT_W-1:0]  num_chunks_q, k_cnt;
    logic              err_q;
    logic              cfg_legal, start_ok, issue, s_wrap, k_last;

    assign cfg_legal = (cfg_num_slots != '0) && (cfg_num_slots <= ADDR_W'(NUM_SLOTS)) &&
                       (cfg_num_chunks != '0);
    assign start_ok  = cfg_start && (state == IDLE) && cfg_legal;
    assign issue     = in_valid && in_ready;
    assign s_wrap    = (s_cnt == num_slots_q - ADDR_W'(1));
    assign k_last    = (k_cnt == num_chunks_q - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        in_ready       = 1'b0;
        pe_cache_clear = 1'b0;
        done           = 1'b0;
        case (state)
            IDLE:  if (start_ok) state_nxt = CLEAR;
            CLEAR: begin
                pe_cache_clear = 1'b1;
                state_nxt      = RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                if (in_valid && s_wrap && k_last) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_slots_q  <= '0;
            num_chunks_q <= '0;
            s_cnt        <= '0;
            k_cnt        <= '0;
            last_rd_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            err_q <= cfg_start && (state == IDLE) && !cfg_legal;
            if (start_ok) begin
                num_slots_q  <= cfg_num_slots;
                num_chunks_q <= cfg_num_chunks;
                s_cnt        <= '0;
                k_cnt        <= '0;
            end else if (issue) begin
                last_rd_q <= s_cnt;
                if (s_wrap) begin
                    s_cnt <= '0;
                    k_cnt <= k_cnt + CNT_W'(1);
                end else begin
                    s_cnt <= s_cnt + ADDR_W'(1);
                end
            end
        end
    end

    assign busy             = (state != IDLE);
    assign cfg_err          = err_q;
    // Read address tracks the live issue, otherwise parks on the last slot read.
    assign pe_cache_rd_addr = issue ? s_cnt : last_rd_q;
    assign pe_bias_en       = issue && (k_cnt == '0);

    pe_acc_wb_pipe #(.ADDR_W(ADDR_W)) u_wb_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (issue),
        .issue_slot (s_cnt),
        .issue_last (k_last),
        .wr_en      (pe_cache_wr_en),
        .wr_addr    (pe_cache_wr_addr),
        .pe_done    (pe_done),
        .out_valid  (out_valid),
        .out_slot   (out_slot)
    );

`ifdef PE_ACC_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else if (start_ok) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (issue && (perf_issue_cnt != '1))
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if ((state == RUN) && !in_valid && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_acc_sched.sv
// Scoreboard bench: stimulus pushes expected writebacks/final sums, a negedge monitor pops and compares.
module tb_pe_acc_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [4:0]  cfg_num_slots = '0;
    logic [11:0] cfg_num_chunks = '0;
    logic        in_valid = 1'b0;
    logic        busy, done, cfg_err, in_ready, pe_cache_clear;
    logic [4:0]  pe_cache_rd_addr, pe_cache_wr_addr, out_slot;
    logic        pe_cache_wr_en, pe_bias_en, pe_done, out_valid;
`ifdef PE_ACC_SCHED_PERF_EN
    logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    pe_acc_sched dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_start        (cfg_start),
        .cfg_num_slots    (cfg_num_slots),
        .cfg_num_chunks   (cfg_num_chunks),
        .busy             (busy),
        .done             (done),
        .cfg_err          (cfg_err),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .pe_cache_clear   (pe_cache_clear),
        .pe_cache_rd_addr (pe_cache_rd_addr),
        .pe_cache_wr_addr (pe_cache_wr_addr),
        .pe_cache_wr_en   (pe_cache_wr_en),
        .pe_bias_en       (pe_bias_en),
        .pe_done          (pe_done),
        .out_valid        (out_valid),
        .out_slot         (out_slot)
`ifdef PE_ACC_SCHED_PERF_EN
        ,
        .perf_issue_cnt   (perf_issue_cnt),
        .perf_stall_cnt   (perf_stall_cnt)
`endif
    );

    typedef struct {
        int slot;
        int last;
    } wb_t;

    wb_t wb_q[$];
    int  out_q[$];
    int  n_chk = 0;
    int  n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s", name);
    endtask

    function automatic int all_outs();
        return int'({busy, done, cfg_err, in_ready, pe_cache_clear, pe_cache_rd_addr,
                     pe_cache_wr_addr, pe_cache_wr_en, pe_bias_en, pe_done, out_valid, out_slot});
    endfunction

    // Monitor: every writeback / final sum must match the oldest outstanding expectation.
    wb_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (pe_cache_wr_en) begin
                if (wb_q.size() == 0) fail_now("unexpected_wr_en");
                else begin
                    mon_e = wb_q.pop_front();
                    chk("wr_addr", int'(pe_cache_wr_addr), mon_e.slot);
                    chk("pe_done", int'(pe_done), mon_e.last);
                end
            end else if (pe_done || out_valid) begin
                fail_now("final_flag_without_wr_en");
            end
            if (out_valid) begin
                if (out_q.size() == 0) fail_now("unexpected_out_valid");
                else chk("out_slot", int'(out_slot), out_q.pop_front());
            end
        end
    end

    // mode 0: in_valid always high; mode 1: alternating 1,0,1,0...
    task automatic run_layer(input int S, input int K, input int mode,
                             input int inj_at, input int abort_at);
        int  s = 0, k = 0, issued = 0, cyc = 0, last_s = 0, d = 0;
        bit  v, inj_prev = 0;
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_num_slots = 5'(S); cfg_num_chunks = 12'(K);
        @(posedge clk); #1;
        cfg_start = 1'b0; cfg_num_slots = 5'd7; cfg_num_chunks = 12'd9;
        @(negedge clk);
        chk("clear_pulse", int'(pe_cache_clear), 1);
        chk("busy_in_clear", int'(busy), 1);
        chk("in_ready_in_clear", int'(in_ready), 0);
        while (issued < S * K && cyc < 2000) begin
            @(posedge clk); #1;
            v = (mode == 0) || (cyc % 2 == 0);
            in_valid = v;
            cfg_start = (issued == inj_at) && v;
            if (cfg_start) begin
                cfg_num_slots = 5'd5; cfg_num_chunks = 12'd1;
            end
            cyc++;
            @(negedge clk);
            if (inj_prev) chk("start_while_busy_no_err", int'(cfg_err), 0);
            inj_prev = cfg_start;
            chk("in_ready_run", int'(in_ready), 1);
            if (v) begin
                chk("rd_addr", int'(pe_cache_rd_addr), s);
                chk("bias_en", int'(pe_bias_en), (k == 0) ? 1 : 0);
                wb_q.push_back('{slot: s, last: (k == K - 1) ? 1 : 0});
                if (k == K - 1) out_q.push_back(s);
                last_s = s;
                issued++;
                s++;
                if (s == S) begin
                    s = 0;
                    k++;
                end
            end else begin
                chk("rd_addr_hold_on_stall", int'(pe_cache_rd_addr), last_s);
                chk("bias_en_on_stall", int'(pe_bias_en), 0);
            end
            if (issued == abort_at) return;
        end
        if (issued < S * K) fail_now("issue_timeout");
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_start = 1'b0;
        if (inj_prev) begin
            @(negedge clk);
            chk("start_while_busy_no_err", int'(cfg_err), 0);
            d = 1;
        end
        while (d < 10) begin
            if (d > 0 || !inj_prev) begin
                if (d == 0) begin
                    @(negedge clk);
                    d = 1;
                end
            end
            if (done) break;
            @(negedge clk);
            d++;
        end
        chk("done_latency", d, 2);
        chk("busy_at_done", int'(busy), 1);
        @(negedge clk);
        chk("busy_after_done", int'(busy), 0);
        chk("done_one_cycle", int'(done), 0);
        chk("wb_q_drained", wb_q.size(), 0);
        chk("out_q_drained", out_q.size(), 0);
    endtask

    task automatic bad_cfg(input int S, input int K);
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_num_slots = 5'(S); cfg_num_chunks = 12'(K);
        @(posedge clk); #1;
        cfg_start = 1'b0;
        @(negedge clk);
        chk("cfg_err_pulse", int'(cfg_err), 1);
        chk("cfg_err_no_busy", int'(busy), 0);
        chk("cfg_err_no_clear", int'(pe_cache_clear), 0);
        @(negedge clk);
        chk("cfg_err_one_cycle", int'(cfg_err), 0);
        chk("cfg_err_still_idle", int'(busy), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_layer(3, 2, 0, -1, -1);
        run_layer(1, 4, 0, -1, -1);
        run_layer(2, 2, 1, -1, -1);
        bad_cfg(0, 2);
        bad_cfg(30, 2);
        bad_cfg(3, 0);

        // Abort mid-layer with k==1 in progress, then a clean layer.
        run_layer(3, 2, 0, -1, 4);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        wb_q.delete();
        out_q.delete();
        chk("midlayer_reset_outputs", all_outs(), 0);
        @(negedge clk);
        chk("midlayer_reset_hold", all_outs(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_layer(3, 2, 0, -1, -1);

        run_layer(2, 3, 0, 2, -1);
        run_layer(29, 1, 0, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
